// File: rtl/median3x3_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : median3x3_stream                                           |
// | Description : Streaming 3x3 median filter over raster-order frames with  |
// |               two internal line buffers, valid/ready on both sides and   |
// |               an end-of-frame flush that drains the last row/column.     |
// | Config      : BORDER_ZERO_EN defined   -> border outputs are 0           |
// |               BORDER_ZERO_EN undefined -> border outputs pass the input  |
// |               pixel through with the same latency as the median path.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module median3x3_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int COL        = 256,
    parameter int ROW        = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CW = $clog2(COL);
    localparam int RW = $clog2(ROW);
    localparam int FW = $clog2(COL + 1);

    localparam logic [CW-1:0] c_col_last  = CW'(COL - 1);
    localparam logic [RW-1:0] c_row_last  = RW'(ROW - 1);
    localparam logic [RW-1:0] c_row_one   = RW'(1);
    localparam logic [FW-1:0] c_flush_end = FW'(COL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] min2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] min3(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] max3(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] med3(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_in_col;
    logic [RW-1:0]   r_in_row;
    logic [CW-1:0]   r_cen_col;
    logic [RW-1:0]   r_cen_row;
    logic [CW-1:0]   r_out_col;
    logic [RW-1:0]   r_out_row;
    logic [CW-1:0]   r_lb_col;
    logic [FW-1:0]   r_flush_cnt;

    logic [DATA_WIDTH-1:0] r_lb0 [COL];
    logic [DATA_WIDTH-1:0] r_lb1 [COL];

    // window of sorted columns, index 0 = oldest (left) column
    logic [DATA_WIDTH-1:0] r_lo  [3];
    logic [DATA_WIDTH-1:0] r_md  [3];
    logic [DATA_WIDTH-1:0] r_hi  [3];
    logic [DATA_WIDTH-1:0] r_ctr [3];
    logic                  r_win_border;
    logic                  r_win_v;

    logic [DATA_WIDTH-1:0] r_cand_a;
    logic [DATA_WIDTH-1:0] r_cand_b;
    logic [DATA_WIDTH-1:0] r_cand_c;
    logic [DATA_WIDTH-1:0] r_s2_ctr;
    logic                  r_s2_border;
    logic                  r_s2_v;

    logic                  w_advance;
    logic                  w_in_state;
    logic                  w_accept;
    logic                  w_flush_slot;
    logic                  w_slot;
    logic                  w_produce;
    logic                  w_hs;
    logic                  w_out_last;
    logic                  w_cen_border;
    logic [DATA_WIDTH-1:0] w_pix;
    logic [DATA_WIDTH-1:0] w_top;
    logic [DATA_WIDTH-1:0] w_mid;
    logic [DATA_WIDTH-1:0] w_border_val;

    assign w_advance    = en & (~out_valid | out_ready);
    assign w_in_state   = (r_state == S_IDLE) | (r_state == S_FILL) | (r_state == S_RUN);
    // reset gates in_ready so nothing is offered while the block is held in reset
    assign in_ready     = reset & w_advance & w_in_state;
    assign w_accept     = in_valid & in_ready;
    assign w_flush_slot = w_advance & (r_state == S_FLUSH);
    assign w_slot       = w_accept | w_flush_slot;
    assign w_produce    = w_slot & ((r_state == S_RUN) | (r_state == S_FLUSH));
    assign w_pix        = (r_state == S_FLUSH) ? '0 : DATA_IN;
    assign w_top        = r_lb1[r_lb_col];
    assign w_mid        = r_lb0[r_lb_col];
    assign w_hs         = out_valid & out_ready & en;
    assign w_out_last   = (r_out_col == c_col_last) & (r_out_row == c_row_last);
    assign frame_done   = w_hs & w_out_last;
    assign busy         = (r_state != S_IDLE);
    // border rule also hides window columns that wrap across a row boundary
    assign w_cen_border = (r_cen_row == '0) | (r_cen_row == c_row_last) |
                          (r_cen_col == '0) | (r_cen_col == c_col_last);

`ifdef BORDER_ZERO_EN
    assign w_border_val = '0;
`else
    assign w_border_val = r_s2_ctr;
`endif

    // frame sequencing and the input / window-centre / output position counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_cen_col   <= '0;
            r_cen_row   <= '0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_lb_col    <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                if (r_in_col == c_col_last) begin
                    r_in_col <= '0;
                    r_in_row <= (r_in_row == c_row_last) ? '0 : r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end
            if (w_produce) begin
                if (r_cen_col == c_col_last) begin
                    r_cen_col <= '0;
                    r_cen_row <= (r_cen_row == c_row_last) ? '0 : r_cen_row + 1'b1;
                end else begin
                    r_cen_col <= r_cen_col + 1'b1;
                end
            end
            if (w_hs) begin
                if (r_out_col == c_col_last) begin
                    r_out_col <= '0;
                    r_out_row <= (r_out_row == c_row_last) ? '0 : r_out_row + 1'b1;
                end else begin
                    r_out_col <= r_out_col + 1'b1;
                end
            end
            if (w_slot) begin
                r_lb_col <= (r_lb_col == c_col_last) ? '0 : r_lb_col + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_state <= S_FILL;
                end
                S_FILL: begin
                    // pixel (1,0) is slot COL, the last of the COL+1 fill slots
                    if (w_accept && r_in_row == c_row_one && r_in_col == '0)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_accept && r_in_row == c_row_last && r_in_col == c_col_last) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                    end
                end
                S_FLUSH: begin
                    if (w_flush_slot) begin
                        if (r_flush_cnt == c_flush_end) begin
                            r_state     <= S_DRAIN;
                            r_flush_cnt <= '0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs && w_out_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // line buffers: read both rows above, then shift the column down one row
    always_ff @(posedge clk) begin
        if (w_slot) begin
            r_lb1[r_lb_col] <= r_lb0[r_lb_col];
            r_lb0[r_lb_col] <= w_pix;
        end
    end

    // sorted-column window, candidate stage and output stage, all moving on advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                r_lo[i]  <= '0;
                r_md[i]  <= '0;
                r_hi[i]  <= '0;
                r_ctr[i] <= '0;
            end
            r_win_border <= 1'b0;
            r_win_v      <= 1'b0;
            r_cand_a     <= '0;
            r_cand_b     <= '0;
            r_cand_c     <= '0;
            r_s2_ctr     <= '0;
            r_s2_border  <= 1'b0;
            r_s2_v       <= 1'b0;
            out_valid    <= 1'b0;
            DATA_OUT     <= '0;
        end else if (w_advance) begin
            r_win_v <= w_produce;
            if (w_slot) begin
                r_lo[0]      <= r_lo[1];
                r_lo[1]      <= r_lo[2];
                r_lo[2]      <= min3(w_top, w_mid, w_pix);
                r_md[0]      <= r_md[1];
                r_md[1]      <= r_md[2];
                r_md[2]      <= med3(w_top, w_mid, w_pix);
                r_hi[0]      <= r_hi[1];
                r_hi[1]      <= r_hi[2];
                r_hi[2]      <= max3(w_top, w_mid, w_pix);
                r_ctr[0]     <= r_ctr[1];
                r_ctr[1]     <= r_ctr[2];
                r_ctr[2]     <= w_mid;
                r_win_border <= w_cen_border;
            end

            r_s2_v <= r_win_v;
            if (r_win_v) begin
                r_cand_a    <= max3(r_lo[0], r_lo[1], r_lo[2]);
                r_cand_b    <= med3(r_md[0], r_md[1], r_md[2]);
                r_cand_c    <= min3(r_hi[0], r_hi[1], r_hi[2]);
                r_s2_ctr    <= r_ctr[1];
                r_s2_border <= r_win_border;
            end

            out_valid <= r_s2_v;
            if (r_s2_v) begin
                DATA_OUT <= r_s2_border ? w_border_val : med3(r_cand_a, r_cand_b, r_cand_c);
            end
        end
    end

endmodule
`default_nettype wire
